fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of first fetched instruction.
REQ-002 SHALL have parameter IMEM_AW, default 14, instruction ROM word-address width.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall_i  in  1  hazard unit request to hold the PC.
REQ-006 SHALL have port redirect_i  in  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port redirect_pc_i  in  32  redirect target byte address.
REQ-008 SHALL have port halt_i  in  1  ecall decoded; halt fetching.
REQ-009 SHALL have port resume_i  in  1  operator confirm; resume fetching.
REQ-010 SHALL have port imem_addr_o  out  IMEM_AW  word address to synchronous ROM with 1-cycle read latency.
REQ-011 SHALL have port imem_data_i  in  32  ROM read data.
REQ-012 SHALL have port pc_o  out  32  byte PC of the instruction on inst_o.
REQ-013 SHALL have port inst_o  out  32  fetched instruction, equal to imem_data_i.
REQ-014 SHALL have port valid_o  out  1  pc_o/inst_o valid for the IF/ID buffer.
REQ-015 SHALL have port clear_o  out  1  flush request to the IF/ID buffer.
REQ-016 SHALL have port halted_o  out  1  high in HALT.
REQ-017 SHALL have port trap_o  out  1  high in TRAP (misaligned redirect).
REQ-018 SHALL have port fetch_cnt_o  out  32  count of cycles with valid_o high and stall_i low.

Function
REQ-019 SHALL hold PC register pc_q; pc_o = pc_q.
REQ-020 SHALL compute next_pc combinationally and drive imem_addr_o = next_pc[IMEM_AW+1:2], so imem_data_i in any cycle is the word at pc_q (zero-bubble fetch).
REQ-021 SHALL use states RUN, HALT, TRAP.
REQ-022 SHALL resolve next_pc by priority: reset -> RESET_PC; redirect_i -> redirect_pc_i; halt_i in RUN -> pc_q; state HALT or TRAP -> pc_q; stall_i -> pc_q; else pc_q+4.
REQ-023 SHALL wrap pc_q+4 modulo 2^32.
REQ-024 SHALL, in RUN with redirect_i high and redirect_pc_i[1:0]==0, load pc_q, assert clear_o and deassert valid_o that cycle; redirect overrides stall_i and halt_i.
REQ-025 SHALL, on redirect_i with redirect_pc_i[1:0]!=0 in RUN or HALT, enter TRAP, load pc_q with the target, and hold it.
REQ-026 SHALL, in RUN with halt_i high and no redirect, enter HALT next cycle with pc_q unchanged, and force valid_o low and clear_o high that cycle.
REQ-027 SHALL, in HALT, keep valid_o low, clear_o high and halted_o high; an aligned redirect updates pc_q and stays in HALT.
REQ-028 SHALL, in HALT with resume_i high and no redirect, return to RUN with pc_q unchanged, so the squashed instruction is re-presented valid next cycle.
REQ-029 SHALL ignore resume_i outside HALT and halt_i outside RUN.
REQ-030 SHALL, in TRAP, keep valid_o low, clear_o high and trap_o high until reset.
REQ-031 SHALL, in RUN with stall_i high and no redirect/halt, hold pc_q and keep valid_o high.
REQ-032 SHALL increment fetch_cnt_o, wrapping at 2^32, in every RUN cycle with valid_o high and stall_i low.

Reset
REQ-033 SHALL, while rst is low at a rising edge, set pc_q=RESET_PC, state=RUN and fetch_cnt_o=0, and drive imem_addr_o from RESET_PC.
REQ-034 SHALL force valid_o=0 and clear_o=1 in every cycle rst is low; reset overrides all inputs in any state.

Structure
REQ-035 SHALL place the state encoding (RUN, HALT, TRAP) and the RESET_PC default in the shared CPU package.
REQ-036 SHALL be a single module without sub-modules; the ROM is external.

Verification
REQ-037 SHALL check: reset release, ROM word i = 0x100+i -> pc_o 0,4,8 with inst_o 0x100,0x101,0x102 on consecutive cycles, valid_o=1.
REQ-038 SHALL check: stall_i high 2 cycles at pc_o=8 -> pc_o stays 8 for those cycles, fetch_cnt_o unchanged, then advances to 12.
REQ-039 SHALL check: redirect_i with redirect_pc_i=0x40 while stall_i high -> clear_o=1 and valid_o=0 that cycle, next pc_o=0x40 valid.
REQ-040 SHALL check: halt_i at pc_o=0x10 -> halted_o=1 and pc_o held at 0x10; resume_i 3 cycles later -> pc_o=0x10 valid, then 0x14.
REQ-041 SHALL check: redirect_pc_i=0x42 -> trap_o=1, valid_o=0 and resume_i without effect until rst low, then pc_o=RESET_PC.
REQ-042 SHALL check: pc_q=0xFFFF_FFFC with no stall -> next pc_o=0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: fetch FSM state encoding and the default boot PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: synchronous ROM port plus the IF/ID buffer feed.
interface fetch_unit_if #(
    parameter int IMEM_AW = 14
);
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [31:0]        imem_data_i;
    logic [31:0]        pc_o;
    logic [31:0]        inst_o;
    logic               valid_o;
    logic               clear_o;

    // valid_o qualifies pc_o/inst_o for the IF/ID buffer every cycle; there is no
    // ready, the consumer back-pressures through stall_i. clear_o flushes IF/ID.
    modport master (
        output imem_addr_o, pc_o, inst_o, valid_o, clear_o,
        input  imem_data_i
    );

    modport slave (
        input  imem_addr_o, pc_o, inst_o, valid_o, clear_o,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT/TRAP control and zero-bubble ROM addressing.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    input  logic         halt_i,
    input  logic         resume_i,
    fetch_unit_if.master bus,
    output logic         halted_o,
    output logic         trap_o,
    output logic [31:0]  fetch_cnt_o,
    output fetch_state_e state_o
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_cnt;

    fetch_state_e w_next_state;
    logic [31:0]  w_next_pc;
    logic         w_valid;
    logic         w_clear;
    logic         w_misaligned;

    assign w_misaligned = (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        r_state <= w_next_state;
        r_pc    <= w_next_pc;
    end

    // The ROM address is derived from next_pc so its registered output lines up with pc_q.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_valid      = 1'b0;
        w_clear      = 1'b1;
        if (!rst) begin
            w_next_state = ST_RUN;
            w_next_pc    = RESET_PC;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (redirect_i) begin
                        w_next_pc = redirect_pc_i;
                        if (w_misaligned) w_next_state = ST_TRAP;
                    end else if (halt_i) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_valid = 1'b1;
                        w_clear = 1'b0;
                        if (!stall_i) w_next_pc = r_pc + 32'd4;
                    end
                end
                ST_HALT: begin
                    if (redirect_i) begin
                        w_next_pc = redirect_pc_i;
                        if (w_misaligned) w_next_state = ST_TRAP;
                    end else if (resume_i) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_TRAP: begin
                    w_next_state = ST_TRAP;
                end
                default: begin
                    w_next_state = ST_TRAP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_valid && !stall_i) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign bus.imem_addr_o = w_next_pc[IMEM_AW+1:2];
    assign bus.pc_o        = r_pc;
    assign bus.inst_o      = bus.imem_data_i;
    assign bus.valid_o     = w_valid;
    assign bus.clear_o     = w_clear;
    assign halted_o        = (r_state == ST_HALT);
    assign trap_o          = (r_state == ST_TRAP);
    assign fetch_cnt_o     = r_fetch_cnt;
    assign state_o         = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected {pc, inst} fetches.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int IMEM_AW = 14;

    logic         clk;
    logic         rst;
    logic         stall_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         halt_i;
    logic         resume_i;
    logic         halted_o;
    logic         trap_o;
    logic [31:0]  fetch_cnt_o;
    fetch_state_e state_o;

    logic [63:0] exp_q[$];
    int n_cmp;
    int n_err;

    fetch_unit_if #(.IMEM_AW(IMEM_AW)) bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .bus           (bus),
        .halted_o      (halted_o),
        .trap_o        (trap_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .state_o       (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM, one-cycle latency, word i holds 0x100 + i
    always @(posedge clk) begin
        bus.imem_data_i <= 32'h0000_0100 + {{(32-IMEM_AW){1'b0}}, bus.imem_addr_o};
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [IMEM_AW-1:0] a;
        a = pc[IMEM_AW+1:2];
        return 32'h0000_0100 + {{(32-IMEM_AW){1'b0}}, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, rom_word(pc)});
    endtask

    // sample at the falling edge; every accepted fetch pops one scoreboard entry
    task automatic to_neg();
        logic [63:0] e;
        @(negedge clk);
        if (bus.valid_o === 1'b1 && stall_i === 1'b0) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed pc %h expected no fetch", bus.pc_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.pc_o, e[63:32]);
                chk("sb_inst", bus.inst_o, e[31:0]);
            end
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        halt_i = 1'b0;
        resume_i = 1'b0;

        // reset
        to_next();
        to_neg();
        chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_clear", {31'b0, bus.clear_o}, 32'd1);
        chk("rst_addr", {18'b0, bus.imem_addr_o}, 32'd0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        chk("rst_halted", {31'b0, halted_o}, 32'd0);
        chk("rst_trap", {31'b0, trap_o}, 32'd0);
        to_next();
        to_neg();
        to_next();
        rst = 1'b1;

        // sequential fetch 0, 4, 8
        push_fetch(32'h0);
        push_fetch(32'h4);
        push_fetch(32'h8);
        to_neg();
        chk("seq_valid", {31'b0, bus.valid_o}, 32'd1);
        to_next();
        to_neg();
        to_next();

        // stall two cycles at pc 8
        stall_i = 1'b1;
        to_neg();
        chk("stall1_pc", bus.pc_o, 32'h8);
        chk("stall1_valid", {31'b0, bus.valid_o}, 32'd1);
        chk("stall1_cnt", fetch_cnt_o, 32'd2);
        to_next();
        to_neg();
        chk("stall2_pc", bus.pc_o, 32'h8);
        chk("stall2_inst", bus.inst_o, 32'h102);
        chk("stall2_cnt", fetch_cnt_o, 32'd2);
        to_next();
        stall_i = 1'b0;
        push_fetch(32'hC);
        to_neg();
        to_next();
        to_neg();
        to_next();
        chk("post_stall_cnt", fetch_cnt_o, 32'd4);

        // halt at pc 0x10, resume three cycles later
        halt_i = 1'b1;
        to_neg();
        chk("halt_pc", bus.pc_o, 32'h10);
        chk("halt_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("halt_clear", {31'b0, bus.clear_o}, 32'd1);
        to_next();
        halt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk("halted", {31'b0, halted_o}, 32'd1);
            chk("halted_pc", bus.pc_o, 32'h10);
            chk("halted_valid", {31'b0, bus.valid_o}, 32'd0);
            to_next();
        end
        resume_i = 1'b1;
        to_neg();
        chk("resume_cycle_valid", {31'b0, bus.valid_o}, 32'd0);
        to_next();
        resume_i = 1'b0;
        push_fetch(32'h10);
        push_fetch(32'h14);
        to_neg();
        chk("resumed_halted", {31'b0, halted_o}, 32'd0);
        chk("resumed_valid", {31'b0, bus.valid_o}, 32'd1);
        to_next();
        to_neg();
        to_next();

        // redirect to 0x40 while stalled
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        to_neg();
        chk("redir_clear", {31'b0, bus.clear_o}, 32'd1);
        chk("redir_valid", {31'b0, bus.valid_o}, 32'd0);
        to_next();
        stall_i = 1'b0;
        redirect_i = 1'b0;
        push_fetch(32'h40);
        to_neg();
        chk("redir_pc", bus.pc_o, 32'h40);
        to_next();
        chk("redir_cnt", fetch_cnt_o, 32'd7);

        // wrap from 0xFFFF_FFFC to 0
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        to_neg();
        to_next();
        redirect_i = 1'b0;
        push_fetch(32'hFFFF_FFFC);
        push_fetch(32'h0);
        to_neg();
        to_next();
        to_neg();
        chk("wrap_pc", bus.pc_o, 32'h0);
        to_next();

        // misaligned redirect traps; resume has no effect
        redirect_i = 1'b1;
        redirect_pc_i = 32'h42;
        to_neg();
        chk("trap_entry_valid", {31'b0, bus.valid_o}, 32'd0);
        to_next();
        redirect_i = 1'b0;
        resume_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("trap", {31'b0, trap_o}, 32'd1);
            chk("trap_valid", {31'b0, bus.valid_o}, 32'd0);
            chk("trap_clear", {31'b0, bus.clear_o}, 32'd1);
            chk("trap_pc", bus.pc_o, 32'h42);
            to_next();
        end
        resume_i = 1'b0;
        chk("trap_cnt", fetch_cnt_o, 32'd9);

        // reset out of TRAP
        rst = 1'b0;
        to_neg();
        chk("rst2_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst2_addr", {18'b0, bus.imem_addr_o}, 32'd0);
        to_next();
        rst = 1'b1;
        push_fetch(32'h0);
        to_neg();
        chk("rst2_trap", {31'b0, trap_o}, 32'd0);
        chk("rst2_pc", bus.pc_o, 32'h0);
        chk("rst2_cnt", fetch_cnt_o, 32'd0);
        to_next();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
